mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 65 ++++++
 rtl/mc_decode.sv | 36 +++
 rtl/mc_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_JR       = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    C_RTYPE   = 4'd0,
    C_JR      = 4'd1,
    C_ITYPE   = 4'd2,
    C_LW      = 4'd3,
    C_SW      = 4'd4,
    C_BEQ     = 4'd5,
    C_J       = 4'd6,
    C_JAL     = 4'd7,
    C_ILLEGAL = 4'd8
  } iclass_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b0100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;
  localparam logic [5:0] FUNC_JR   = 6'b001000;

  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_R31 = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam logic [1:0] NPC_SEQ    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - op/func classification feeding the controller FSM
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    iclass,
  output logic [3:0] alu_op
);

  // Map the instruction fields to a class plus the ALU operation it needs
  always_comb begin
    iclass = C_ILLEGAL;
    alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (func)
          FUNC_ADDU: begin iclass = C_RTYPE; alu_op = ALU_ADD; end
          FUNC_SUBU: begin iclass = C_RTYPE; alu_op = ALU_SUB; end
          FUNC_SLT:  begin iclass = C_RTYPE; alu_op = ALU_SLT; end
          FUNC_JR:   iclass = C_JR;
          default:   iclass = C_ILLEGAL;
        endcase
      end
      OP_ORI:  begin iclass = C_ITYPE; alu_op = ALU_OR;  end
      OP_LUI:  begin iclass = C_ITYPE; alu_op = ALU_LUI; end
      OP_LW:   iclass = C_LW;
      OP_SW:   iclass = C_SW;
      OP_BEQ:  iclass = C_BEQ;
      OP_J:    iclass = C_J;
      OP_JAL:  iclass = C_JAL;
      default: iclass = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle processor controller FSM
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        reg_wr,
  output logic        mem_wr,
  output logic [1:0]  reg_dst,
  output logic        alu_src,
  output logic [1:0]  mem_to_reg,
  output logic        ext_op,
  output logic [3:0]  alu_ctr,
  output logic [1:0]  npc_sel,
  output logic        illegal,
  output logic [31:0] instr_cnt,
  output logic [3:0]  state
);

  state_t     cur, nxt;
  iclass_t    iclass;
  logic [3:0] alu_op;

  mc_decode u_decode (
    .op     (op),
    .func   (func),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  assign state = cur;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Retire counter: any return to FETCH from an execute-phase state
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      instr_cnt <= 32'd0;
    else if (cur != S_FETCH && cur != S_DECODE && nxt == S_FETCH)
      instr_cnt <= instr_cnt + 32'd1;
  end

  // Next-state and per-state control outputs; reset forces every output low
  always_comb begin
    nxt        = cur;
    mem_req    = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    reg_dst    = REG_DST_RT;
    alu_src    = 1'b0;
    mem_to_reg = M2R_ALU;
    ext_op     = 1'b0;
    alu_ctr    = ALU_ADD;
    npc_sel    = NPC_SEQ;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (iclass)
          C_RTYPE: nxt = S_EXEC_R;
          C_JR:    nxt = S_JR;
          C_ITYPE: nxt = S_EXEC_I;
          C_LW:    nxt = S_MEM_ADDR;
          C_SW:    nxt = S_MEM_ADDR;
          C_BEQ:   nxt = S_BRANCH;
          C_J:     nxt = S_JUMP;
          C_JAL:   nxt = S_JAL;
          default: begin
            illegal = 1'b1;
            nxt     = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src = 1'b0;
        alu_ctr = alu_op;
        nxt     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src = 1'b1;
        ext_op  = 1'b0;
        alu_ctr = alu_op;
        nxt     = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = M2R_ALU;
        reg_dst    = (iclass == C_RTYPE) ? REG_DST_RD : REG_DST_RT;
        nxt        = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_ctr = ALU_ADD;
        alu_src = 1'b1;
        ext_op  = 1'b1;
        nxt     = (iclass == C_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready) nxt = S_MEM_WB;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_MEM_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = M2R_MEM;
        reg_dst    = REG_DST_RT;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        alu_ctr = ALU_SUB;
        alu_src = 1'b0;
        ext_op  = 1'b1;
        npc_sel = NPC_BRANCH;
        pc_wr   = zero;
        nxt     = S_FETCH;
      end
      S_JUMP: begin
        pc_wr   = 1'b1;
        npc_sel = NPC_JUMP;
        nxt     = S_FETCH;
      end
      S_JAL: begin
        pc_wr      = 1'b1;
        npc_sel    = NPC_JUMP;
        reg_wr     = 1'b1;
        reg_dst    = REG_DST_R31;
        mem_to_reg = M2R_PC;
        nxt        = S_FETCH;
      end
      S_JR: begin
        pc_wr   = 1'b1;
        npc_sel = NPC_JR;
        nxt     = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
    if (reset) begin
      mem_req    = 1'b0;
      ir_wr      = 1'b0;
      pc_wr      = 1'b0;
      reg_wr     = 1'b0;
      mem_wr     = 1'b0;
      reg_dst    = 2'd0;
      alu_src    = 1'b0;
      mem_to_reg = 2'd0;
      ext_op     = 1'b0;
      alu_ctr    = 4'd0;
      npc_sel    = 2'd0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl
module tb_mc_ctrl;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, func;
  logic        zero, mem_ready;
  logic        mem_req, ir_wr, pc_wr, reg_wr, mem_wr, alu_src, ext_op, illegal;
  logic [1:0]  reg_dst, mem_to_reg, npc_sel;
  logic [3:0]  alu_ctr, state;
  logic [31:0] instr_cnt;

  typedef struct packed {
    logic       mem_req;
    logic       ir_wr;
    logic       pc_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] mem_to_reg;
    logic       ext_op;
    logic [3:0] alu_ctr;
    logic [1:0] npc_sel;
    logic       illegal;
    logic [3:0] st;
  } out_t;

  typedef struct {
    out_t e;
    logic rdy;
    logic z;
  } rec_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
  localparam int K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = 32'd0;
  rec_t        q[$];
  out_t        obs;

  assign obs = '{mem_req, ir_wr, pc_wr, reg_wr, mem_wr, reg_dst, alu_src,
                 mem_to_reg, ext_op, alu_ctr, npc_sel, illegal, state};

  mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .func       (func),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .ir_wr      (ir_wr),
    .pc_wr      (pc_wr),
    .reg_wr     (reg_wr),
    .mem_wr     (mem_wr),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .ext_op     (ext_op),
    .alu_ctr    (alu_ctr),
    .npc_sel    (npc_sel),
    .illegal    (illegal),
    .instr_cnt  (instr_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] o, input logic [31:0] e, input string tag);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000) begin
      if (f == 6'b100001 || f == 6'b100011 || f == 6'b101010) return K_R;
      if (f == 6'b001000) return K_JR;
      return K_ILL;
    end
    case (o)
      6'b001101, 6'b001111: return K_I;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b001101) return 4'b0010;
    if (o == 6'b001111) return 4'b0100;
    if (f == 6'b100011) return 4'b0001;
    if (f == 6'b101010) return 4'b0011;
    return 4'b0000;
  endfunction

  task automatic push(input out_t e, input logic rdy, input logic z);
    rec_t r;
    r.e = e; r.rdy = rdy; r.z = z;
    q.push_back(r);
  endtask

  // Expected cycle-by-cycle trace of one instruction, from the ISA timing rules
  task automatic build(input logic [5:0] o, input logic [5:0] f, input int fw,
                       input int mw, input logic z);
    out_t e;
    int   k;
    k = kind_of(o, f);
    for (int i = 0; i < fw; i++) begin
      e = '0; e.st = S_FETCH; e.mem_req = 1'b1;
      push(e, 1'b0, 1'($urandom));
    end
    e = '0; e.st = S_FETCH; e.mem_req = 1'b1; e.ir_wr = 1'b1; e.pc_wr = 1'b1;
    push(e, 1'b1, 1'($urandom));
    e = '0; e.st = S_DECODE; e.illegal = (k == K_ILL);
    push(e, 1'($urandom), 1'($urandom));
    case (k)
      K_R, K_I: begin
        e = '0; e.st = (k == K_R) ? S_EXEC_R : S_EXEC_I;
        e.alu_src = (k == K_I); e.alu_ctr = alu_of(o, f);
        push(e, 1'($urandom), 1'($urandom));
        e = '0; e.st = S_ALU_WB; e.reg_wr = 1'b1; e.reg_dst = (k == K_R) ? 2'd1 : 2'd0;
        push(e, 1'($urandom), 1'($urandom));
      end
      K_LW, K_SW: begin
        e = '0; e.st = S_MEM_ADDR; e.alu_src = 1'b1; e.ext_op = 1'b1;
        push(e, 1'($urandom), 1'($urandom));
        e = '0; e.st = (k == K_LW) ? S_MEM_RD : S_MEM_WR;
        e.mem_req = 1'b1; e.mem_wr = (k == K_SW);
        for (int i = 0; i < mw; i++) push(e, 1'b0, 1'($urandom));
        push(e, 1'b1, 1'($urandom));
        if (k == K_LW) begin
          e = '0; e.st = S_MEM_WB; e.reg_wr = 1'b1; e.mem_to_reg = 2'd1;
          push(e, 1'($urandom), 1'($urandom));
        end
      end
      K_BEQ: begin
        e = '0; e.st = S_BRANCH; e.alu_ctr = 4'b0001; e.ext_op = 1'b1;
        e.npc_sel = 2'd1; e.pc_wr = z;
        push(e, 1'($urandom), z);
      end
      K_J: begin
        e = '0; e.st = S_JUMP; e.pc_wr = 1'b1; e.npc_sel = 2'd2;
        push(e, 1'($urandom), 1'($urandom));
      end
      K_JAL: begin
        e = '0; e.st = S_JAL; e.pc_wr = 1'b1; e.npc_sel = 2'd2;
        e.reg_wr = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
        push(e, 1'($urandom), 1'($urandom));
      end
      K_JR: begin
        e = '0; e.st = S_JR; e.pc_wr = 1'b1; e.npc_sel = 2'd3;
        push(e, 1'($urandom), 1'($urandom));
      end
      default: ;
    endcase
    if (k != K_ILL) exp_cnt = exp_cnt + 32'd1;
  endtask

  // Play the queued trace; inputs change just after posedge, outputs sampled at negedge
  task automatic run_q(input string tag);
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      mem_ready = r.rdy;
      zero      = r.z;
      @(negedge clk);
      chk(32'(obs), 32'(r.e), tag);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exec(input logic [5:0] o, input logic [5:0] f, input int fw,
                      input int mw, input logic z, input string tag);
    op = o; func = f;
    build(o, f, fw, mw, z);
    run_q(tag);
    chk(instr_cnt, exp_cnt, {tag, "_cnt"});
  endtask

  logic [5:0] tbl_op   [11];
  logic [5:0] tbl_func [11];

  initial begin
    out_t e;
    int   idx;
    tbl_op   = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
                 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
    tbl_func = '{6'b100001, 6'b100011, 6'b101010, 6'b001000, 6'b000000, 6'b000000,
                 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};

    reset = 1'b1; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = '0; e.st = S_FETCH;
    chk(32'(obs), 32'(e), "reset_outputs");
    chk(instr_cnt, 32'd0, "reset_cnt");
    @(posedge clk);
    #1;
    reset = 1'b0;

    exec(6'b000000, 6'b100001, 0, 0, 1'b0, "addu");
    exec(6'b100011, 6'b000000, 0, 2, 1'b0, "lw_wait2");
    exec(6'b000100, 6'b000000, 0, 0, 1'b0, "beq_nt");
    exec(6'b000100, 6'b000000, 0, 0, 1'b1, "beq_t");
    exec(6'b111111, 6'b000000, 0, 0, 1'b0, "illegal_op");
    exec(6'b000000, 6'b111111, 1, 0, 1'b0, "illegal_func");
    exec(6'b000011, 6'b000000, 0, 0, 1'b0, "jal");
    exec(6'b101011, 6'b000000, 2, 1, 1'b0, "sw_wait");

    // Abort a store while it waits in MEM_WR
    op = 6'b101011; func = 6'b000000;
    build(op, func, 0, 4, 1'b0);
    void'(q.pop_back());
    void'(q.pop_back());
    void'(q.pop_back());
    run_q("sw_abort");
    reset = 1'b1;
    #1;
    e = '0; e.st = S_FETCH;
    chk(32'(obs), 32'(e), "abort_outputs");
    chk(instr_cnt, 32'd0, "abort_cnt");
    exp_cnt = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exec(6'b000000, 6'b000000 | 6'b100011, 0, 0, 1'b0, "subu_after_reset");

    for (int n = 0; n < 200; n++) begin
      idx = $urandom_range(0, 12);
      if (idx < 11)
        exec(tbl_op[idx], tbl_func[idx], $urandom_range(0, 2), $urandom_range(0, 3),
             1'($urandom), "rand");
      else if (idx == 11)
        exec(6'($urandom), 6'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
             1'($urandom), "rand_op");
      else
        exec(6'b000000, 6'($urandom), $urandom_range(0, 2), 0, 1'($urandom), "rand_func");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
